// File: rtl/flip_icon_buffer_pkg.sv
// Shared constants, types and sizing helpers for the flip icon buffer.
package lagd_flip_icon_pkg;

  localparam int DEFAULT_NUM_SPIN        = 256;
  localparam int DEFAULT_FLIP_ICON_DEPTH = 1024;
  localparam int DEFAULT_HOST_DW         = 32;
  localparam int DEFAULT_ADDR_W          = $clog2(DEFAULT_FLIP_ICON_DEPTH);

  typedef logic [DEFAULT_NUM_SPIN-1:0] icon_t;
  typedef logic [DEFAULT_ADDR_W:0]     icon_addr_t;

  // Host words per icon.
  function automatic int calc_wpe(input int num_spin, input int host_dw);
    return num_spin / host_dw;
  endfunction

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flip_icon_buffer_if.sv
// Host load/readback and macro flip-read signals of the flip icon buffer.
interface flip_icon_buffer_if
  import lagd_flip_icon_pkg::*;
#(
  parameter int NUM_SPIN        = DEFAULT_NUM_SPIN,
  parameter int FLIP_ICON_DEPTH = DEFAULT_FLIP_ICON_DEPTH,
  parameter int HOST_DW         = DEFAULT_HOST_DW
);

  localparam int ADDR_W = $clog2(FLIP_ICON_DEPTH);
  localparam int WPE    = calc_wpe(NUM_SPIN, HOST_DW);
  localparam int WIDX_W = idx_width(WPE);

  logic                host_wvalid_i;
  logic                host_wready_o;
  logic [HOST_DW-1:0]  host_wdata_i;
  logic                host_rd_req_i;
  logic                host_rd_ready_o;
  logic [ADDR_W-1:0]   host_rd_addr_i;
  logic [WIDX_W-1:0]   host_rd_word_i;
  logic                host_rd_valid_o;
  logic [HOST_DW-1:0]  host_rd_data_o;
  logic                flip_ren_i;
  logic [ADDR_W:0]     flip_raddr_i;
  logic [NUM_SPIN-1:0] flip_rdata_o;

  modport master (
    output host_wvalid_i, host_wdata_i,
    input  host_wready_o,
    output host_rd_req_i, host_rd_addr_i, host_rd_word_i,
    input  host_rd_ready_o, host_rd_valid_o, host_rd_data_o,
    output flip_ren_i, flip_raddr_i,
    input  flip_rdata_o
  );

  modport slave (
    input  host_wvalid_i, host_wdata_i,
    output host_wready_o,
    input  host_rd_req_i, host_rd_addr_i, host_rd_word_i,
    output host_rd_ready_o, host_rd_valid_o, host_rd_data_o,
    input  flip_ren_i, flip_raddr_i,
    output flip_rdata_o
  );

endinterface

// File: rtl/flip_icon_buffer_word_packer.sv
// Assembles host words into one icon; word 0 lands in the LSBs and the last
// word produces a same-edge commit of the complete icon.
module flip_icon_word_packer
  import lagd_flip_icon_pkg::*;
#(
  parameter int NUM_SPIN = DEFAULT_NUM_SPIN,
  parameter int HOST_DW  = DEFAULT_HOST_DW
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                en,
  input  logic                clear,
  input  logic                lock,
  input  logic                full,
  input  logic                wvalid,
  input  logic [HOST_DW-1:0]  wdata,
  output logic                wready,
  output logic                commit,
  output logic [NUM_SPIN-1:0] icon
);

  localparam int WPE    = calc_wpe(NUM_SPIN, HOST_DW);
  localparam int WIDX_W = idx_width(WPE);
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(WPE - 1);

  logic [WIDX_W-1:0]   word_idx_reg;
  logic [NUM_SPIN-1:0] asm_reg;
  logic [NUM_SPIN-1:0] icon_next;
  logic                accept;

  // Readiness is combinational so a stalled host can simply hold wvalid.
  assign wready = ~srst & en & ~lock & ~clear & ~full;
  assign accept = wvalid & wready;
  assign commit = accept & (word_idx_reg == LAST_IDX);

  always_comb begin
    icon_next = asm_reg;
    icon_next[word_idx_reg*HOST_DW +: HOST_DW] = wdata;
  end

  assign icon = icon_next;

  always_ff @(posedge clk) begin
    if (srst) begin
      word_idx_reg <= '0;
      asm_reg      <= '0;
    end else if (en) begin
      if (clear) begin
        word_idx_reg <= '0;
        asm_reg      <= '0;
      end else if (accept) begin
        if (commit) begin
          word_idx_reg <= '0;
          asm_reg      <= '0;
        end else begin
          word_idx_reg <= word_idx_reg + WIDX_W'(1);
          asm_reg      <= icon_next;
        end
      end
    end
  end

endmodule

// File: rtl/flip_icon_buffer.sv
// Flip icon store feeding the compute macro: host load via the word packer,
// one shared read port serving macro flip reads (priority) and host readback.
module flip_icon_buffer
  import lagd_flip_icon_pkg::*;
#(
  parameter int NUM_SPIN        = DEFAULT_NUM_SPIN,
  parameter int FLIP_ICON_DEPTH = DEFAULT_FLIP_ICON_DEPTH,
  parameter int HOST_DW         = DEFAULT_HOST_DW
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             en_i,
  input  logic                             clear_i,
  input  logic                             lock_i,
  flip_icon_buffer_if.slave                bus,
  output logic [$clog2(FLIP_ICON_DEPTH):0] icon_last_raddr_plus_one_o,
  output logic                             full_o
);

  localparam int ADDR_W = $clog2(FLIP_ICON_DEPTH);
  localparam int WPE    = calc_wpe(NUM_SPIN, HOST_DW);
  localparam int WIDX_W = idx_width(WPE);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(FLIP_ICON_DEPTH);

  logic [NUM_SPIN-1:0] mem [FLIP_ICON_DEPTH];
  logic [NUM_SPIN-1:0] rd_data_reg;
  logic [HOST_DW-1:0]  rd_words [WPE];

  logic [ADDR_W:0]     count_reg;
  logic [ADDR_W:0]     count_next;
  logic                full_reg;

  logic                commit;
  logic [NUM_SPIN-1:0] commit_icon;
  logic                wready;

  logic                flip_fire;
  logic                host_fire;
  logic                host_rd_ready;
  logic                flip_in_range;
  logic                host_in_range;
  logic [ADDR_W-1:0]   rd_addr;

  logic                flip_live_reg;
  logic                flip_zero_reg;
  logic [NUM_SPIN-1:0] flip_hold_reg;
  logic [NUM_SPIN-1:0] flip_view;
  logic                host_live_reg;
  logic                host_zero_reg;
  logic [WIDX_W-1:0]   host_word_reg;
  logic [HOST_DW-1:0]  host_hold_reg;
  logic [HOST_DW-1:0]  host_view;
  logic                host_valid_reg;

  flip_icon_word_packer #(
    .NUM_SPIN (NUM_SPIN),
    .HOST_DW  (HOST_DW)
  ) u_packer (
    .clk    (clk_i),
    .srst   (rst_i),
    .en     (en_i),
    .clear  (clear_i),
    .lock   (lock_i),
    .full   (full_reg),
    .wvalid (bus.host_wvalid_i),
    .wdata  (bus.host_wdata_i),
    .wready (wready),
    .commit (commit),
    .icon   (commit_icon)
  );

  assign host_rd_ready = ~rst_i & en_i & ~bus.flip_ren_i;
  assign flip_fire     = ~rst_i & en_i & bus.flip_ren_i;
  assign host_fire     = bus.host_rd_req_i & host_rd_ready;
  assign flip_in_range = bus.flip_raddr_i < count_reg;
  assign host_in_range = {1'b0, bus.host_rd_addr_i} < count_reg;
  assign rd_addr       = flip_fire ? bus.flip_raddr_i[ADDR_W-1:0] : bus.host_rd_addr_i;

  // Single write / single read port; the NBA ordering gives read-before-write.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      mem[count_reg[ADDR_W-1:0]] <= commit_icon;
    end
    if (flip_fire || host_fire) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  always_comb begin
    count_next = count_reg;
    if (clear_i) begin
      count_next = '0;
    end else if (commit) begin
      count_next = count_reg + (ADDR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_reg <= '0;
      full_reg  <= 1'b0;
    end else if (en_i) begin
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_CNT);
    end
  end

  for (genvar gi = 0; gi < WPE; gi++) begin : g_rd_words
    assign rd_words[gi] = rd_data_reg[gi*HOST_DW +: HOST_DW];
  end

  // The read register is shared, so each consumer keeps a private copy of its
  // last result once the other consumer takes the port.
  always_comb begin
    flip_view = flip_hold_reg;
    if (flip_live_reg) begin
      flip_view = flip_zero_reg ? '0 : rd_data_reg;
    end
  end

  always_comb begin
    host_view = host_hold_reg;
    if (host_live_reg) begin
      host_view = host_zero_reg ? '0 : rd_words[host_word_reg];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flip_live_reg  <= 1'b0;
      flip_zero_reg  <= 1'b0;
      flip_hold_reg  <= '0;
      host_live_reg  <= 1'b0;
      host_zero_reg  <= 1'b0;
      host_word_reg  <= '0;
      host_hold_reg  <= '0;
      host_valid_reg <= 1'b0;
    end else if (en_i) begin
      host_valid_reg <= host_fire;
      if (flip_fire) begin
        flip_live_reg <= 1'b1;
        flip_zero_reg <= ~flip_in_range;
      end else if (host_fire && flip_live_reg) begin
        flip_hold_reg <= flip_view;
        flip_live_reg <= 1'b0;
      end
      if (host_fire) begin
        host_live_reg <= 1'b1;
        host_zero_reg <= ~host_in_range;
        host_word_reg <= bus.host_rd_word_i;
      end else if (flip_fire && host_live_reg) begin
        host_hold_reg <= host_view;
        host_live_reg <= 1'b0;
      end
    end
  end

  assign bus.host_wready_o        = wready;
  assign bus.host_rd_ready_o      = host_rd_ready;
  assign bus.host_rd_valid_o      = host_valid_reg;
  assign bus.host_rd_data_o       = host_view;
  assign bus.flip_rdata_o         = flip_view;
  assign icon_last_raddr_plus_one_o = count_reg;
  assign full_o                   = full_reg;

endmodule

// File: tb/tb_flip_icon_buffer.sv
// Directed bench for flip_icon_buffer (4-icon configuration) with a read
// scoreboard checked by an independent negedge monitor.
module tb_flip_icon_buffer;

  localparam int NS    = 256;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 2;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b1;
  logic          clear = 1'b0;
  logic          lock  = 1'b0;
  logic [AW:0]   count_o;
  logic          full_o;

  int            errors = 0;
  int            checks = 0;
  logic [NS-1:0] flip_q [$];
  logic [DW-1:0] host_q [$];
  logic          flip_pending = 1'b0;
  logic [NS-1:0] mon_flip_exp;
  logic [DW-1:0] mon_host_exp;

  flip_icon_buffer_if #(.NUM_SPIN(NS), .FLIP_ICON_DEPTH(DEPTH), .HOST_DW(DW)) bus ();

  flip_icon_buffer #(.NUM_SPIN(NS), .FLIP_ICON_DEPTH(DEPTH), .HOST_DW(DW)) dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .en_i                       (en),
    .clear_i                    (clear),
    .lock_i                     (lock),
    .bus                        (bus),
    .icon_last_raddr_plus_one_o (count_o),
    .full_o                     (full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [NS-1:0] mk_icon(input logic [DW-1:0] base);
    logic [NS-1:0] v;
    for (int k = 0; k < NS / DW; k++) v[k*DW +: DW] = base + DW'(k);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    int n;
    n = 0;
    bus.host_wvalid_i = 1'b1;
    bus.host_wdata_i  = d;
    #1;
    while (!bus.host_wready_o && n < 50) begin
      tick();
      #1;
      n++;
    end
    if (!bus.host_wready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: wready=0 after %0d cycles, required 1", n);
    end
    $display("host write %h", d);
    tick();
    bus.host_wvalid_i = 1'b0;
  endtask

  task automatic load_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) send_word(base + DW'(i));
  endtask

  task automatic flip_read(input logic [AW:0] addr, input logic [NS-1:0] exp);
    bus.flip_ren_i   = 1'b1;
    bus.flip_raddr_i = addr;
    flip_q.push_back(exp);
    tick();
    bus.flip_ren_i = 1'b0;
  endtask

  task automatic host_rd(input logic [AW-1:0] addr, input logic [2:0] word, input logic [DW-1:0] exp);
    int n;
    n = 0;
    bus.host_rd_req_i  = 1'b1;
    bus.host_rd_addr_i = addr;
    bus.host_rd_word_i = word;
    #1;
    while (!bus.host_rd_ready_o && n < 50) begin
      tick();
      #1;
      n++;
    end
    if (!bus.host_rd_ready_o) begin
      checks++;
      errors++;
      $display("FAIL rd_timeout: rd_ready=0 after %0d cycles, required 1", n);
    end
    host_q.push_back(exp);
    tick();
    bus.host_rd_req_i = 1'b0;
  endtask

  // Monitor: a flip read accepted at a posedge is due at the next negedge;
  // host readback is due whenever host_rd_valid_o is high.
  always @(posedge clk) flip_pending <= bus.flip_ren_i & en & ~rst;

  always @(negedge clk) begin
    if (flip_pending) begin
      if (flip_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL flip_unexpected: got data %h with no read outstanding", bus.flip_rdata_o);
      end else begin
        mon_flip_exp = flip_q.pop_front();
        check("flip_rdata", bus.flip_rdata_o, mon_flip_exp);
        $display("flip read data=%h", bus.flip_rdata_o);
      end
    end
    if (bus.host_rd_valid_o) begin
      if (host_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL host_unexpected: got valid data %h, required no valid", bus.host_rd_data_o);
      end else begin
        mon_host_exp = host_q.pop_front();
        check("host_rd_data", NS'(bus.host_rd_data_o), NS'(mon_host_exp));
        $display("host read data=%h", bus.host_rd_data_o);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.host_wvalid_i  = 1'b0;
    bus.host_wdata_i   = '0;
    bus.host_rd_req_i  = 1'b0;
    bus.host_rd_addr_i = '0;
    bus.host_rd_word_i = '0;
    bus.flip_ren_i     = 1'b0;
    bus.flip_raddr_i   = '0;

    // Reset state
    tick();
    check("wready_in_rst", NS'(bus.host_wready_o), '0);
    check("rd_ready_in_rst", NS'(bus.host_rd_ready_o), '0);
    tick();
    rst = 1'b0;
    #1;
    check("count_rst", NS'(count_o), '0);
    check("full_rst", NS'(full_o), '0);
    check("flip_rdata_rst", bus.flip_rdata_o, '0);
    check("host_rd_data_rst", NS'(bus.host_rd_data_o), '0);
    check("host_rd_valid_rst", NS'(bus.host_rd_valid_o), '0);
    check("wready_idle", NS'(bus.host_wready_o), NS'(1));
    tick();

    // Two icons, words 0x1..0x10
    load_words(32'h1, 8);
    check("count_1", NS'(count_o), NS'(1));
    load_words(32'h9, 8);
    check("count_2", NS'(count_o), NS'(2));
    check("full_2", NS'(full_o), '0);
    flip_read(3'd5, '0);
    flip_read(3'd2, '0);
    flip_read(3'd0, mk_icon(32'h1));
    flip_read(3'd1, mk_icon(32'h9));
    tick();
    tick();
    check("flip_hold", bus.flip_rdata_o, mk_icon(32'h9));

    // Flip read and host readback in the same cycle
    bus.flip_ren_i     = 1'b1;
    bus.flip_raddr_i   = 3'd1;
    bus.host_rd_req_i  = 1'b1;
    bus.host_rd_addr_i = 2'd0;
    bus.host_rd_word_i = 3'd2;
    flip_q.push_back(mk_icon(32'h9));
    #1;
    check("rd_ready_blocked", NS'(bus.host_rd_ready_o), '0);
    tick();
    bus.flip_ren_i = 1'b0;
    #1;
    check("rd_ready_free", NS'(bus.host_rd_ready_o), NS'(1));
    host_q.push_back(32'h3);
    tick();
    bus.host_rd_req_i = 1'b0;
    tick();
    check("rd_valid_pulse", NS'(bus.host_rd_valid_o), '0);
    host_rd(2'd1, 3'd7, 32'h10);
    tick();
    flip_read(3'd0, mk_icon(32'h1));
    tick();
    check("host_hold", NS'(bus.host_rd_data_o), NS'(32'h10));
    host_rd(2'd3, 3'd0, 32'h0);
    tick();
    check("flip_hold_after_host", bus.flip_rdata_o, mk_icon(32'h1));

    // Clear with a flip read against the pre-clear count
    load_words(32'h11, 8);
    check("count_3", NS'(count_o), NS'(3));
    bus.host_wvalid_i = 1'b1;
    bus.host_wdata_i  = 32'hDEAD_BEEF;
    clear = 1'b1;
    bus.flip_ren_i   = 1'b1;
    bus.flip_raddr_i = 3'd2;
    flip_q.push_back(mk_icon(32'h11));
    #1;
    check("wready_clear", NS'(bus.host_wready_o), '0);
    tick();
    clear = 1'b0;
    bus.flip_ren_i    = 1'b0;
    bus.host_wvalid_i = 1'b0;
    check("count_clear", NS'(count_o), '0);
    check("full_clear", NS'(full_o), '0);

    // Fill to capacity and stall
    load_words(32'h1, 32);
    check("count_full", NS'(count_o), NS'(4));
    check("full_set", NS'(full_o), NS'(1));
    check("wready_full", NS'(bus.host_wready_o), '0);
    bus.host_wvalid_i = 1'b1;
    bus.host_wdata_i  = 32'hEEEE_EEEE;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("wready_stall", NS'(bus.host_wready_o), '0);
      tick();
    end
    bus.host_wvalid_i = 1'b0;
    check("count_stall", NS'(count_o), NS'(4));
    flip_read(3'd0, mk_icon(32'h1));
    flip_read(3'd3, mk_icon(32'h19));
    flip_read(3'd4, '0);

    // Lock pauses assembly mid-icon
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("count_clear2", NS'(count_o), '0);
    check("full_clear2", NS'(full_o), '0);
    load_words(32'h100, 3);
    lock = 1'b1;
    bus.host_wvalid_i = 1'b1;
    bus.host_wdata_i  = 32'h0000_0BAD;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("wready_lock", NS'(bus.host_wready_o), '0);
      tick();
    end
    bus.host_wvalid_i = 1'b0;
    lock = 1'b0;
    load_words(32'h103, 5);
    check("count_lock", NS'(count_o), NS'(1));
    flip_read(3'd0, mk_icon(32'h100));

    // Reset mid-load discards the partial icon
    load_words(32'h300, 4);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("count_rst2", NS'(count_o), '0);
    check("flip_rdata_rst2", bus.flip_rdata_o, '0);
    load_words(32'h400, 8);
    check("count_fresh", NS'(count_o), NS'(1));
    flip_read(3'd0, mk_icon(32'h400));
    flip_read(3'd1, '0);
    flip_read(3'd0, mk_icon(32'h400));

    // Enable low freezes state and ignores ren / clear
    en = 1'b0;
    clear = 1'b1;
    bus.flip_ren_i   = 1'b1;
    bus.flip_raddr_i = 3'd1;
    #1;
    check("wready_en_low", NS'(bus.host_wready_o), '0);
    check("rd_ready_en_low", NS'(bus.host_rd_ready_o), '0);
    tick();
    tick();
    bus.flip_ren_i = 1'b0;
    clear = 1'b0;
    check("count_en_low", NS'(count_o), NS'(1));
    check("flip_en_low", bus.flip_rdata_o, mk_icon(32'h400));
    en = 1'b1;
    tick();
    tick();

    check("flip_q_drained", NS'(flip_q.size()), '0);
    check("host_q_drained", NS'(host_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
